// File: rtl/alu_op_sequencer.sv
// Serial-load controller for the 8-bit ALU: collects A, B and an op byte over one
// handshake bus, holds operands stable for a fixed settle time, then presents the result.
module alu_op_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [1:0]         alu_s,
    input  logic [7:0]         alu_result,
    output logic [7:0]         res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       chain;
    logic       xfer;
    logic       consume;
    logic       fire;

    assign xfer    = in_valid & in_ready;
    assign consume = res_valid & res_ready;
    assign fire    = (state == EXEC) && (cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= GET_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            GET_A: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = GET_OP;
            end
            GET_OP: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (fire) state_nxt = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (consume) state_nxt = chain ? GET_B : GET_A;
            end
            default: state_nxt = GET_A;
        endcase
    end

    // Operand registers only move on their own capture edge, so the ALU sees
    // constant inputs for the whole settle window and while the result waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            chain     <= 1'b0;
            cnt       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                GET_A:  if (xfer) alu_a <= in_data;
                GET_B:  if (xfer) alu_b <= in_data;
                GET_OP: begin
                    if (xfer) begin
                        alu_s <= in_data[1:0];
                        chain <= in_data[7];
                        cnt   <= EXEC_LOAD;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (fire) begin
                        res_data  <= alu_result;
                        res_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + COUNT_W'(1);
                        if (chain) alu_a <= res_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: three instances cover the default build,
// a 4-cycle settle build and a 2-bit op counter build.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data    [3];
    logic       in_valid   [3];
    logic       in_ready   [3];
    logic [7:0] alu_a      [3];
    logic [7:0] alu_b      [3];
    logic [1:0] alu_s      [3];
    logic [7:0] alu_result [3];
    logic [7:0] res_data   [3];
    logic       res_valid  [3];
    logic       res_ready  [3];
    logic       busy       [3];
    logic [7:0] op_count   [3];
    logic [1:0] op_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] s);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result[0] = alu_model(alu_a[0], alu_b[0], alu_s[0]);
    assign alu_result[1] = alu_model(alu_a[1], alu_b[1], alu_s[1]);
    assign alu_result[2] = alu_model(alu_a[2], alu_b[2], alu_s[2]);
    assign op_count[2]   = {6'd0, op_cnt2};

    alu_op_sequencer #(.EXEC_CYCLES(1), .COUNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]),
        .alu_result(alu_result[0]), .res_data(res_data[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    alu_op_sequencer #(.EXEC_CYCLES(4), .COUNT_W(8)) u_lat (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]),
        .alu_result(alu_result[1]), .res_data(res_data[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    alu_op_sequencer #(.EXEC_CYCLES(1), .COUNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_s(alu_s[2]),
        .alu_result(alu_result[2]), .res_data(res_data[2]), .res_valid(res_valid[2]),
        .res_ready(res_ready[2]), .busy(busy[2]), .op_count(op_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the sequencer takes it (bounded).
    task automatic send(input int i, input logic [7:0] d);
        int n = 0;
        in_data[i]  = d;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, in_ready[i]}, 32'd1);
        step();
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_res(input int i);
        int n = 0;
        while (!res_valid[i] && n < 20) begin
            step();
            n++;
        end
        chk("res_valid_wait", {31'd0, res_valid[i]}, 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        for (int i = 0; i < 3; i++) begin
            in_data[i]   = 8'h00;
            in_valid[i]  = 1'b0;
            res_ready[i] = 1'b1;
        end

        // Reset state
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready",  {31'd0, in_ready[i]},  32'd1);
            chk("rst_res_valid", {31'd0, res_valid[i]}, 32'd0);
            chk("rst_busy",      {31'd0, busy[i]},      32'd0);
            chk("rst_op_count",  {24'd0, op_count[i]},  32'd0);
        end
        chk("rst_alu_a", {24'd0, alu_a[0]}, 32'd0);
        chk("rst_res_data", {24'd0, res_data[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic add, EXEC_CYCLES=1
        send(0, 8'h12);
        send(0, 8'h34);
        send(0, 8'h00);
        chk("t1_busy_exec", {31'd0, busy[0]}, 32'd1);
        chk("t1_rv_exec", {31'd0, res_valid[0]}, 32'd0);
        chk("t1_in_ready_exec", {31'd0, in_ready[0]}, 32'd0);
        step();
        chk("t1_rv", {31'd0, res_valid[0]}, 32'd1);
        chk("t1_res", {24'd0, res_data[0]}, 32'h46);
        chk("t1_cnt_before", {24'd0, op_count[0]}, 32'd0);
        step();
        chk("t1_rv_drop", {31'd0, res_valid[0]}, 32'd0);
        chk("t1_cnt", {24'd0, op_count[0]}, 32'd1);
        chk("t1_idle", {31'd0, in_ready[0]}, 32'd1);
        chk("t1_busy_idle", {31'd0, busy[0]}, 32'd0);

        // Backpressure with ignored input pulses
        res_ready[0] = 1'b0;
        send(0, 8'hF0);
        send(0, 8'h0F);
        send(0, 8'h03);
        step();
        for (int k = 0; k < 10; k++) begin
            in_data[0]  = 8'hAA;
            in_valid[0] = k[0];
            step();
            chk("t2_rv_held", {31'd0, res_valid[0]}, 32'd1);
            chk("t2_res", {24'd0, res_data[0]}, 32'hFF);
            chk("t2_in_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        in_valid[0] = 1'b0;
        chk("t2_alu_a", {24'd0, alu_a[0]}, 32'hF0);
        chk("t2_cnt_held", {24'd0, op_count[0]}, 32'd1);
        res_ready[0] = 1'b1;
        step();
        chk("t2_rv_drop", {31'd0, res_valid[0]}, 32'd0);
        chk("t2_cnt", {24'd0, op_count[0]}, 32'd2);
        chk("t2_idle", {31'd0, in_ready[0]}, 32'd1);

        // Chain: 5+3=8, then 8-2=6 without a new A byte
        send(0, 8'h05);
        send(0, 8'h03);
        send(0, 8'h80);
        step();
        chk("t3_res1", {24'd0, res_data[0]}, 32'h08);
        step();
        chk("t3_alu_a_fb", {24'd0, alu_a[0]}, 32'h08);
        chk("t3_ready_b", {31'd0, in_ready[0]}, 32'd1);
        chk("t3_cnt1", {24'd0, op_count[0]}, 32'd3);
        send(0, 8'h02);
        send(0, 8'h01);
        chk("t3_alu_a_exec", {24'd0, alu_a[0]}, 32'h08);
        chk("t3_alu_b_exec", {24'd0, alu_b[0]}, 32'h02);
        step();
        chk("t3_res2", {24'd0, res_data[0]}, 32'h06);
        step();
        chk("t3_cnt2", {24'd0, op_count[0]}, 32'd4);
        chk("t3_busy_idle", {31'd0, busy[0]}, 32'd0);

        // Latency, EXEC_CYCLES=4: 0x3C & 0x0F = 0x0C
        send(1, 8'h3C);
        send(1, 8'h0F);
        send(1, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t4_rv_early", {31'd0, res_valid[1]}, 32'd0);
            chk("t4_alu_a", {24'd0, alu_a[1]}, 32'h3C);
            chk("t4_alu_b", {24'd0, alu_b[1]}, 32'h0F);
            chk("t4_alu_s", {30'd0, alu_s[1]}, 32'd2);
        end
        step();
        chk("t4_rv", {31'd0, res_valid[1]}, 32'd1);
        chk("t4_res", {24'd0, res_data[1]}, 32'h0C);
        step();
        chk("t4_cnt", {24'd0, op_count[1]}, 32'd1);

        // Reset in GET_B
        send(0, 8'h11);
        pulse_rst();
        chk("t5_b_alu_a", {24'd0, alu_a[0]}, 32'd0);
        chk("t5_b_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("t5_b_cnt", {24'd0, op_count[0]}, 32'd0);
        rst = 1'b0;
        step();
        // Reset in EXEC
        send(0, 8'h22);
        send(0, 8'h01);
        send(0, 8'h00);
        chk("t5_e_busy_pre", {31'd0, busy[0]}, 32'd1);
        pulse_rst();
        chk("t5_e_busy", {31'd0, busy[0]}, 32'd0);
        chk("t5_e_alu_b", {24'd0, alu_b[0]}, 32'd0);
        chk("t5_e_ready", {31'd0, in_ready[0]}, 32'd1);
        rst = 1'b0;
        step();
        // Reset in HOLD
        res_ready[0] = 1'b0;
        send(0, 8'h33);
        send(0, 8'h01);
        send(0, 8'h00);
        step();
        chk("t5_h_rv_pre", {31'd0, res_valid[0]}, 32'd1);
        pulse_rst();
        chk("t5_h_rv", {31'd0, res_valid[0]}, 32'd0);
        chk("t5_h_res", {24'd0, res_data[0]}, 32'd0);
        chk("t5_h_cnt", {24'd0, op_count[0]}, 32'd0);
        rst = 1'b0;
        res_ready[0] = 1'b1;
        step();
        send(0, 8'h07);
        send(0, 8'h01);
        send(0, 8'h00);
        wait_res(0);
        chk("t5_res", {24'd0, res_data[0]}, 32'h08);
        step();
        chk("t5_cnt", {24'd0, op_count[0]}, 32'd1);

        // Wrap on 2-bit counter; op 0x7D = sub with bits [6:2] all set
        for (int i = 0; i < 5; i++) begin
            send(2, 8'(i + 3));
            send(2, 8'h01);
            send(2, 8'h7D);
            wait_res(2);
            chk("t6_res", {24'd0, res_data[2]}, 32'(i + 2));
            step();
            chk("t6_cnt", {30'd0, op_cnt2}, {30'd0, wrap_exp[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
